// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
// whack_pkg : shared types and constants for the whack_engine reaction game
// Rev 1.0   : initial release
// ============================================================================
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GAP_WAIT = 2'd1,
    LIT      = 2'd2,
    JUDGE    = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback from taps 16,14,13,11 (bit positions 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [7:0]  TOKEN_SAT = 8'd255;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage : whack_pkg
`default_nettype wire

// File: rtl/whack_lfsr.sv
`default_nettype none
// ============================================================================
// whack_lfsr : 16-bit Fibonacci LFSR with step, 8-bit XOR inject, zero guard
// Rev 1.0    : initial release
// ============================================================================
module whack_lfsr
  import whack_pkg::*;
#(
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             inject,
  input  logic [7:0]       inj_data,
  output logic [RND_W-1:0] rnd_nxt
);

  logic [15:0] lfsr_q, lfsr_d, lfsr_raw;

  always_comb begin
    lfsr_raw = lfsr_q;
    if (step || inject) lfsr_raw = lfsr_step(lfsr_q);
    if (inject)         lfsr_raw = lfsr_raw ^ {8'h00, inj_data};
    // An all-zero state would lock up, so fall back to the seed.
    lfsr_d = (lfsr_raw == 16'h0000) ? LFSR_SEED : lfsr_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  // Consumers latch at state entry, so they see the value that will be current.
  assign rnd_nxt = lfsr_d[RND_W-1:0];

endmodule : whack_lfsr
`default_nettype wire

// File: rtl/whack_engine.sv
`default_nettype none
// ============================================================================
// whack_engine : whack-a-light reaction game engine (lights, judge, score)
// Optional shrinking window via macro WHACK_SPEEDUP_EN.
// Rev 1.0      : initial release
// ============================================================================
module whack_engine
  import whack_pkg::*;
#(
  parameter int N_LIGHTS    = 8,
  parameter int CNT_W       = 30,
  parameter int WINDOW      = 50_000_000,
  parameter int GAP         = 25_000_000,
  parameter int TOKEN_SHIFT = 18,
  parameter int MIN_WINDOW  = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [N_LIGHTS-1:0] switch,
  output logic [N_LIGHTS-1:0] LED,
  output logic                hit,
  output logic                miss,
  output logic [7:0]          token,
  output logic [7:0]          score,
  output logic                busy
);

  localparam int IDX_W = $clog2(N_LIGHTS);
  localparam int RND_W = (IDX_W > 4) ? IDX_W : 4;
  localparam logic [N_LIGHTS-1:0] ONE_HOT0 = N_LIGHTS'(1);

  if ((N_LIGHTS < 2) || (N_LIGHTS > 32) || ((N_LIGHTS & (N_LIGHTS - 1)) != 0)) begin : g_bad_lights
    $error("N_LIGHTS must be a power of two in 2..32");
  end
  if ((MIN_WINDOW < 1) || (MIN_WINDOW > WINDOW)) begin : g_bad_window
    $error("MIN_WINDOW must lie in 1..WINDOW");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     gap_last_q, gap_last_d;
  logic [IDX_W-1:0]     target_q, target_d;
  logic [N_LIGHTS-1:0]  switch_q, chg, led_vec;
  logic                 hit_q, hit_d, miss_q, miss_d;
  logic [7:0]           token_q, token_d, score_q, score_d, react_tok;
  logic [CNT_W-1:0]     react_shift, window_cur;
  logic [RND_W-1:0]     rnd_nxt;

  whack_lfsr #(.RND_W(RND_W)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (state_q == GAP_WAIT),
    .inject   (state_q == JUDGE),
    .inj_data (token_q),
    .rnd_nxt  (rnd_nxt)
  );

  assign chg     = switch ^ switch_q;
  assign led_vec = (state_q == LIT) ? (ONE_HOT0 << target_q) : '0;

  always_comb begin
    react_shift = cnt_q >> TOKEN_SHIFT;
    react_tok   = (react_shift > CNT_W'(TOKEN_SAT)) ? TOKEN_SAT : react_shift[7:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    gap_last_d = gap_last_q;
    target_d   = target_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    token_d    = token_q;
    score_d    = score_q;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (run) begin
          state_d    = GAP_WAIT;
          cnt_d      = '0;
          gap_last_d = CNT_W'(GAP) + CNT_W'(rnd_nxt[3:0]) - CNT_W'(1);
        end
      end
      GAP_WAIT: begin
        if (cnt_q == gap_last_q) begin
          state_d  = LIT;
          cnt_d    = '0;
          target_d = rnd_nxt[IDX_W-1:0];
        end
      end
      LIT: begin
        if (chg == led_vec) begin
          state_d = JUDGE;
          hit_d   = 1'b1;
          token_d = react_tok;
          score_d = (score_q == TOKEN_SAT) ? score_q : score_q + 8'd1;
        end else if ((chg != '0) || (cnt_q == window_cur - CNT_W'(1))) begin
          state_d = JUDGE;
          miss_d  = 1'b1;
          token_d = TOKEN_SAT;
        end
      end
      JUDGE: begin
        if (run) begin
          state_d    = GAP_WAIT;
          cnt_d      = '0;
          gap_last_d = CNT_W'(GAP) + CNT_W'(rnd_nxt[3:0]) - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WHACK_SPEEDUP_EN
  logic [CNT_W-1:0] window_q, window_d, window_shrunk;

  always_comb begin
    window_shrunk = window_q - (window_q >> 3);
    window_d      = window_q;
    if (hit_d)
      window_d = (window_shrunk < CNT_W'(MIN_WINDOW)) ? CNT_W'(MIN_WINDOW) : window_shrunk;
    else if (miss_d)
      window_d = CNT_W'(WINDOW);
  end

  always_ff @(posedge clk) begin
    if (rst) window_q <= CNT_W'(WINDOW);
    else     window_q <= window_d;
  end

  assign window_cur = window_q;
`else
  assign window_cur = CNT_W'(WINDOW);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gap_last_q <= '0;
      target_q   <= '0;
      switch_q   <= switch;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      token_q    <= 8'd0;
      score_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_last_q <= gap_last_d;
      target_q   <= target_d;
      switch_q   <= switch;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      token_q    <= token_d;
      score_q    <= score_d;
    end
  end

  assign LED   = led_vec;
  assign hit   = hit_q;
  assign miss  = miss_q;
  assign token = token_q;
  assign score = score_q;
  assign busy  = (state_q != IDLE);

endmodule : whack_engine
`default_nettype wire

// File: doc/whack_engine.md
WHACK_ENGINE -- requirements
Module: whack_engine

Interface
REQ-001 Parameter N_LIGHTS, default 8: light/switch channel count, power of two, 2..32.
REQ-002 Parameter CNT_W, default 30: width of all cycle counters.
REQ-003 Parameter WINDOW, default 50_000_000: cycles a light stays lit awaiting a flip.
REQ-004 Parameter GAP, default 25_000_000: base dark cycles between rounds.
REQ-005 Parameter TOKEN_SHIFT, default 18: right shift applied to reaction cycles to form token.
REQ-006 Parameter MIN_WINDOW, default 5_000_000: window floor under speed-up.
REQ-007 clk  input  1  system clock; single clock domain.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 run  input  1  level; high keeps rounds going, low returns to idle at round end.
REQ-010 switch  input  N_LIGHTS  player switches, synchronous to clk.
REQ-011 LED  output  N_LIGHTS  one-hot target light, zero when not lit.
REQ-012 hit  output  1  one-cycle pulse, correct switch flipped in window.
REQ-013 miss  output  1  one-cycle pulse, wrong switch or timeout.
REQ-014 token  output  8  last reaction time, held until next judgement.
REQ-015 score  output  8  saturating hit count.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, GAP_WAIT, LIT, JUDGE.
REQ-018 IDLE -> GAP_WAIT when run=1; cycle counter cleared on entry to GAP_WAIT and LIT.
REQ-019 GAP_WAIT SHALL last GAP + lfsr[3:0] cycles, then -> LIT.
REQ-020 On LIT entry, target index = lfsr[log2(N_LIGHTS)-1:0]; LED = 1<<index for every LIT cycle.
REQ-021 Edge vector chg = switch ^ switch_q (switch_q registered each cycle); either flip direction counts.
REQ-022 In LIT at counter c: chg == LED -> JUDGE with hit; chg nonzero and != LED (incl. target plus another bit same cycle) -> JUDGE with miss; chg==0 and c == window-1 -> JUDGE with miss.
REQ-023 Edges in GAP_WAIT, JUDGE, IDLE SHALL be ignored.
REQ-024 JUDGE lasts exactly one cycle: hit or miss asserted there, LED=0; token = min(255, c>>TOKEN_SHIFT) on hit, 255 on miss.
REQ-025 On hit, score increments, saturating at 255; miss leaves score unchanged.
REQ-026 In JUDGE, LFSR advances once with token XORed into its low 8 bits; then -> GAP_WAIT if run=1, else IDLE.
REQ-027 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances one step per GAP_WAIT cycle; all-zero value SHALL be replaced by seed 16'hACE1.
REQ-028 run dropping mid-round SHALL not abort; the round completes through JUDGE.
REQ-029 hit and miss SHALL never be high together.

Reset
REQ-030 rst SHALL force: state IDLE, LED=0, hit=0, miss=0, token=0, score=0, lfsr=16'hACE1, window=WINDOW, counter=0, switch_q<=switch (no spurious edge after reset).
REQ-031 rst during any state SHALL abort the round on the next clock edge with no hit/miss pulse.

Configuration
REQ-032 Macro WHACK_SPEEDUP_EN defined: each hit sets window = max(MIN_WINDOW, window - (window>>3)); a miss restores window = WINDOW.
REQ-033 Macro undefined: window is constant WINDOW; speed-up logic absent.

Structure
REQ-034 Package whack_pkg SHALL hold the state enum, LFSR seed and tap constants, token saturation value 255.
REQ-035 Sub-module whack_lfsr SHALL implement the LFSR with step, inject (8-bit XOR) and zero-guard.

Verification (N_LIGHTS=8, WINDOW=20, GAP=4, TOKEN_SHIFT=0, MIN_WINDOW=8)
REQ-036 Reset then run=1, flip target switch at LIT counter 5 -> hit pulse 1 cycle, token=5, score=1, LED=0 in JUDGE.
REQ-037 No flip during LIT -> miss at counter 19 transition, token=255, score unchanged.
REQ-038 Flip non-target bit, then separately target+other bit same cycle in next round -> miss both times.
REQ-039 Assert rst mid-LIT -> next cycle LED=0, score=0, busy=0, no hit/miss.
REQ-040 With WHACK_SPEEDUP_EN: three consecutive hits -> window 20,18,16,14; then miss -> window 20; without macro window stays 20.
REQ-041 Drop run during LIT -> round judged, then IDLE, busy=0; 300 hits -> score holds 255.
